// File: rtl/dac_spi_pkg.sv
// rtl/dac_spi_pkg.sv - shared types and constants for the laser DAC SPI transmitter
package dac_spi_pkg;

  localparam int DAC_W     = 14;
  localparam int FRAME_W   = 16;
  localparam int BIT_CNT_W = 4;

  localparam logic [1:0] CTRL_BITS_DEF = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    LDAC,
    DONE
  } state_t;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - SCLK half-period divider with sync restart
module spi_tick_gen
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int             CW   = cnt_width(CLK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i_n) begin
    if (!rst_i_n) begin
      cnt_q <= '0;
    end else if (clr_i || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - serialises DAC codes into 16-bit SPI frames with LDAC strobe
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int         CLK_DIV   = 4,
  parameter int         LDAC_W    = 2,
  parameter logic [1:0] CTRL_BITS = CTRL_BITS_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i_n,
  input  logic             en_i,
  input  logic [DAC_W-1:0] dac_i,
  input  logic             dac_stb_i,
  output logic             spi_sclk_o,
  output logic             spi_cs_o_n,
  output logic             spi_mosi_o,
  output logic             dac_ldac_o_n,
  output logic             busy_o,
  output logic             done_stb_o,
  output logic             ovr_stb_o
);

  localparam int                   LCW       = cnt_width(LDAC_W);
  localparam logic [LCW-1:0]       LDAC_LAST = LCW'(LDAC_W - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(FRAME_W - 1);

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic                 phase_q, phase_d;
  logic [LCW-1:0]       ldac_cnt_q, ldac_cnt_d;
  logic [DAC_W-1:0]     pend_val_q, pend_val_d;
  logic                 pend_q, pend_d;
  logic                 tick, tick_clr, req;
  logic                 sclk_d, cs_n_d, mosi_d, ldac_n_d, busy_d, done_d, ovr_d;

  assign req      = dac_stb_i & en_i;
  // Restarting the divider on SETUP entry keeps frame phase independent of strobe timing.
  assign tick_clr = (state_d == SETUP) && (state_q != SETUP);

  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_i_n(rst_i_n),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_q      <= '0;
      phase_q    <= 1'b0;
      ldac_cnt_q <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      ldac_cnt_q <= ldac_cnt_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = SETUP;
      SETUP:   if (tick) state_d = SHIFT;
      SHIFT:   if (tick && phase_q && (bit_q == BIT_LAST)) state_d = HOLD;
      HOLD:    if (tick) state_d = LDAC;
      LDAC:    if (ldac_cnt_q == LDAC_LAST) state_d = DONE;
      DONE:    state_d = (pend_q || req) ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shreg_d    = shreg_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    ldac_cnt_d = ldac_cnt_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    ovr_d      = 1'b0;
    case (state_q)
      IDLE: if (req) shreg_d = {CTRL_BITS, dac_i};
      SETUP: begin
        bit_d   = '0;
        phase_d = 1'b0;
      end
      SHIFT: if (tick) begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          bit_d   = bit_q + 1'b1;
          shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
        end
      end
      HOLD: ldac_cnt_d = '0;
      LDAC: ldac_cnt_d = ldac_cnt_q + 1'b1;
      default: ;
    endcase

    // A strobe landing on DONE is not an overwrite: the older value is consumed this cycle.
    if (state_q == DONE) begin
      if (pend_q) begin
        shreg_d = {CTRL_BITS, pend_val_q};
        pend_d  = req;
        if (req) pend_val_d = dac_i;
      end else if (req) begin
        shreg_d = {CTRL_BITS, dac_i};
      end
    end else if ((state_q != IDLE) && req) begin
      pend_d     = 1'b1;
      pend_val_d = dac_i;
      ovr_d      = pend_q;
    end
  end

  always_comb begin
    sclk_d   = (state_d == SHIFT) && phase_d;
    cs_n_d   = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
    mosi_d   = ((state_d == SETUP) || (state_d == SHIFT)) && shreg_d[FRAME_W-1];
    ldac_n_d = (state_d != LDAC);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_i_n) begin
    if (!rst_i_n) begin
      spi_sclk_o   <= 1'b0;
      spi_cs_o_n   <= 1'b1;
      spi_mosi_o   <= 1'b0;
      dac_ldac_o_n <= 1'b1;
      busy_o       <= 1'b0;
      done_stb_o   <= 1'b0;
      ovr_stb_o    <= 1'b0;
    end else begin
      spi_sclk_o   <= sclk_d;
      spi_cs_o_n   <= cs_n_d;
      spi_mosi_o   <= mosi_d;
      dac_ldac_o_n <= ldac_n_d;
      busy_o       <= busy_d;
      done_stb_o   <= done_d;
      ovr_stb_o    <= ovr_d;
    end
  end

endmodule
